// File: rtl/sr_frame_deserializer.sv
// Frame deserialiser for the serial output of a DFF shift chain.
// It hunts for a sync word and confirms it over LOCK_CNT consecutive frames.
// Once locked, it cuts each frame's payload into WIDTH-bit words, MSB first.
// Words are offered through a single-entry valid/ready output buffer.
// WIDTH and SYNC_LEN are assumed to be at least 2.
module sr_frame_deserializer #(
    parameter int                  WIDTH       = 8,
    parameter int                  SYNC_LEN    = 8,
    parameter logic [SYNC_LEN-1:0] SYNC        = 8'hA5,
    parameter int                  FRAME_WORDS = 2,
    parameter int                  LOCK_CNT    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_sof,
    output logic             locked,
    output logic             sync_lost,
    output logic             overflow
);

    localparam int WB_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WI_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int SB_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam int MC_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;
    typedef enum logic {PH_PAYLOAD, PH_SYNC} phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    // Only the newest SYNC_LEN-1 bits are kept; the incoming bit completes the window.
    logic [SYNC_LEN-2:0] window_q, window_d;
    logic [SB_W-1:0]     sbit_q, sbit_d;
    logic [WB_W-1:0]     wbit_q, wbit_d;
    logic [WI_W-1:0]     widx_q, widx_d;
    logic [MC_W-1:0]     match_q, match_d;
    logic [WIDTH-2:0]    shreg_q, shreg_d;
    logic [WIDTH-1:0]    o_data_q, o_data_d;
    logic                o_valid_q, o_valid_d;
    logic                o_sof_q, o_sof_d;
    logic                sync_lost_q, sync_lost_d;
    logic                overflow_q, overflow_d;

    logic [SYNC_LEN-1:0] window_nx;
    logic [WIDTH-1:0]    shreg_nx;
    logic                sync_hit;
    logic                word_done;
    logic                word_first;

    assign window_nx = {window_q, i_bit};
    assign shreg_nx  = {shreg_q, i_bit};
    assign sync_hit  = (window_nx == SYNC);

    // State and datapath registers; reset overrides everything, including a frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            phase_q     <= PH_PAYLOAD;
            window_q    <= '0;
            sbit_q      <= '0;
            wbit_q      <= '0;
            widx_q      <= '0;
            match_q     <= '0;
            shreg_q     <= '0;
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
            o_sof_q     <= 1'b0;
            sync_lost_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            window_q    <= window_d;
            sbit_q      <= sbit_d;
            wbit_q      <= wbit_d;
            widx_q      <= widx_d;
            match_q     <= match_d;
            shreg_q     <= shreg_d;
            o_data_q    <= o_data_d;
            o_valid_q   <= o_valid_d;
            o_sof_q     <= o_sof_d;
            sync_lost_q <= sync_lost_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next state: sync hunting, frame phase counting, word assembly and output buffering.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        window_d    = window_q;
        sbit_d      = sbit_q;
        wbit_d      = wbit_q;
        widx_d      = widx_q;
        match_d     = match_q;
        shreg_d     = shreg_q;
        o_data_d    = o_data_q;
        o_valid_d   = o_valid_q;
        o_sof_d     = o_sof_q;
        sync_lost_d = 1'b0;
        overflow_d  = overflow_q;
        word_done   = 1'b0;
        word_first  = 1'b0;

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        if (i_valid) begin
            window_d = window_nx[SYNC_LEN-2:0];
            if (state_q == ST_HUNT) begin
                if (sync_hit) begin
                    match_d = MC_W'(1);
                    state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                    phase_d = PH_PAYLOAD;
                    sbit_d  = '0;
                    wbit_d  = '0;
                    widx_d  = '0;
                end
            end else if (phase_q == PH_PAYLOAD) begin
                // Words are assembled in VERIFY too but only delivered when LOCKED.
                shreg_d = shreg_nx[WIDTH-2:0];
                if (wbit_q == WB_W'(WIDTH - 1)) begin
                    wbit_d     = '0;
                    word_done  = (state_q == ST_LOCKED);
                    word_first = (widx_q == '0);
                    if (widx_q == WI_W'(FRAME_WORDS - 1)) begin
                        widx_d  = '0;
                        phase_d = PH_SYNC;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end else begin
                    wbit_d = wbit_q + 1'b1;
                end
            end else begin
                if (sbit_q == SB_W'(SYNC_LEN - 1)) begin
                    sbit_d  = '0;
                    phase_d = PH_PAYLOAD;
                    if (sync_hit) begin
                        if (state_q == ST_VERIFY) begin
                            match_d = match_q + 1'b1;
                            if (match_d == MC_W'(LOCK_CNT)) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else begin
                        // Hunting resumes from the current window on the next sampled bit.
                        state_d     = ST_HUNT;
                        match_d     = '0;
                        sync_lost_d = (state_q == ST_LOCKED);
                    end
                end else begin
                    sbit_d = sbit_q + 1'b1;
                end
            end
        end

        if (word_done) begin
            if (!o_valid_q || o_ready) begin
                o_data_d  = shreg_nx;
                o_sof_d   = word_first;
                o_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    assign o_data    = o_data_q;
    assign o_valid   = o_valid_q;
    assign o_sof     = o_sof_q;
    assign locked    = (state_q == ST_LOCKED);
    assign sync_lost = sync_lost_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sr_frame_deserializer.sv
// Scoreboard bench for sr_frame_deserializer with the default parameters.
// A frame-level reference model turns each bit stream into expected words.
// A negedge monitor pops and compares words whenever the DUT hands one over.
module tb_sr_frame_deserializer;

    localparam int         WIDTH  = 8;
    localparam int         FW     = 2;
    localparam int         LOCK_N = 2;
    localparam logic [7:0] SYNC_B = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_bit = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ready = 1'b1;
    logic       o_sof;
    logic       locked;
    logic       sync_lost;
    logic       overflow;

    int n_checks = 0;
    int n_fail = 0;
    int gap_mode = 0;
    int lost_seen = 0;
    int exp_lost = 0;
    int lost_base = 0;

    logic [8:0] exp_q[$];
    bit         stim_q[$];
    logic [8:0] e_mon;

    sr_frame_deserializer #(
        .WIDTH(WIDTH), .SYNC_LEN(8), .SYNC(SYNC_B), .FRAME_WORDS(FW), .LOCK_CNT(LOCK_N)
    ) dut (
        .clk(clk), .rst(rst), .i_bit(i_bit), .i_valid(i_valid),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_sof(o_sof),
        .locked(locked), .sync_lost(sync_lost), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted word against the scoreboard; count sync_lost pulses.
    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {23'd0, o_sof, o_data}, 32'hFFFF_FFFF);
            end else begin
                e_mon = exp_q.pop_front();
                $display("word data=%02h sof=%0b expected data=%02h sof=%0b", o_data, o_sof, e_mon[7:0], e_mon[8]);
                check("word_data", 32'(o_data), 32'(e_mon[7:0]));
                check("word_sof", 32'(o_sof), 32'(e_mon[8]));
            end
        end
        if (!rst && sync_lost) lost_seen++;
    end

    function automatic void add_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) stim_q.push_back(b[k]);
    endfunction

    // Frame-level reference: find a sync, then walk frame by frame (payload words, then sync byte).
    function automatic void model_run();
        int         p = 0;
        int         n = stim_q.size();
        int         m = 0;
        bit         lk = 1'b0;
        bit         hunting = 1'b1;
        logic [7:0] win = 8'h00;
        logic [7:0] by;
        exp_lost = 0;
        while (p < n) begin
            if (hunting) begin
                win = {win[6:0], stim_q[p]};
                p++;
                if (win == SYNC_B) begin
                    hunting = 1'b0;
                    m = 1;
                    lk = (LOCK_N == 1);
                end
            end else begin
                for (int w = 0; w < FW && p + 8 <= n; w++) begin
                    by = 8'h00;
                    for (int k = 0; k < 8; k++) by = {by[6:0], stim_q[p + k]};
                    p += 8;
                    if (lk) exp_q.push_back({(w == 0), by});
                end
                if (p + 8 > n) begin
                    p = n;
                end else begin
                    by = 8'h00;
                    for (int k = 0; k < 8; k++) by = {by[6:0], stim_q[p + k]};
                    p += 8;
                    win = by;
                    if (by == SYNC_B) begin
                        m++;
                        if (m >= LOCK_N) lk = 1'b1;
                    end else begin
                        if (lk) exp_lost++;
                        lk = 1'b0;
                        m = 0;
                        hunting = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic send_bit(input bit b);
        int gaps = 0;
        if (gap_mode == 1) gaps = 1;
        else if (gap_mode == 2) gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        repeat (gaps) begin
            i_valid = 1'b0;
            @(posedge clk); #1;
        end
        i_bit = b;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i <= to; i++) send_bit(stim_q[i]);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_o_data", 32'(o_data), 32'h0);
        check("rst_o_valid", 32'(o_valid), 32'h0);
        check("rst_o_sof", 32'(o_sof), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_sync_lost", 32'(sync_lost), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        rst = 1'b0;
        exp_q.delete();
        stim_q.delete();
        lost_base = lost_seen;
    endtask

    task automatic finish_scn(input string name, input logic exp_ovf);
        idle(3);
        check({name, "_pending_words"}, 32'(exp_q.size()), 32'h0);
        check({name, "_sync_lost_count"}, 32'(lost_seen - lost_base), 32'(exp_lost));
        check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic add_base_stream();
        add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22);
        add_byte(8'hA5); add_byte(8'h33); add_byte(8'h44);
        add_byte(8'hA5); add_byte(8'h55); add_byte(8'h66);
        add_byte(8'hA5);
    endtask

    initial begin
        // Lock and deliver, contiguous input, with lock and word latency checks.
        gap_mode = 0;
        o_ready = 1'b1;
        do_reset();
        add_base_stream();
        model_run();
        send_range(0, 30);
        check("locked_before_2nd_sync_end", 32'(locked), 32'h0);
        send_range(31, 31);
        check("locked_after_2nd_sync_end", 32'(locked), 32'h1);
        send_range(32, 39);
        check("word33_valid_latency", 32'(o_valid), 32'h1);
        check("word33_data_latency", 32'(o_data), 32'h33);
        send_range(40, stim_q.size() - 1);
        finish_scn("lock_deliver", 1'b0);

        // Same stream with alternating valid.
        gap_mode = 1;
        do_reset();
        add_base_stream();
        model_run();
        send_range(0, stim_q.size() - 1);
        finish_scn("gapped", 1'b0);

        // Backpressure across words 33 and 44: 33 held, 44 dropped.
        gap_mode = 0;
        do_reset();
        o_ready = 1'b0;
        add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22);
        add_byte(8'hA5); add_byte(8'h33); add_byte(8'h44); add_byte(8'hA5);
        send_range(0, stim_q.size() - 1);
        idle(2);
        check("bp_held_valid", 32'(o_valid), 32'h1);
        check("bp_held_data", 32'(o_data), 32'h33);
        check("bp_overflow", 32'(overflow), 32'h1);
        exp_q.push_back(9'h133);
        o_ready = 1'b1;
        idle(1);
        stim_q.delete();
        add_byte(8'h55); add_byte(8'h66); add_byte(8'hA5);
        exp_q.push_back(9'h155);
        exp_q.push_back(9'h066);
        send_range(0, stim_q.size() - 1);
        exp_lost = 0;
        finish_scn("backpressure", 1'b1);

        // Loss of lock and relock.
        do_reset();
        add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22);
        add_byte(8'hA5); add_byte(8'h33); add_byte(8'h44); add_byte(8'h5A);
        add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22);
        add_byte(8'hA5); add_byte(8'h77); add_byte(8'h88);
        model_run();
        send_range(0, stim_q.size() - 1);
        check("relock_locked", 32'(locked), 32'h1);
        finish_scn("loss_of_lock", 1'b0);

        // False sync inside VERIFY payload followed by a bad sync.
        do_reset();
        add_byte(8'hA5); add_byte(8'hA5); add_byte(8'h11); add_byte(8'h00);
        model_run();
        send_range(0, stim_q.size() - 1);
        check("false_sync_locked", 32'(locked), 32'h0);
        finish_scn("false_sync", 1'b0);

        // Reset halfway through word 55 while 33 is held.
        do_reset();
        o_ready = 1'b0;
        add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22);
        add_byte(8'hA5); add_byte(8'h33); add_byte(8'h44);
        add_byte(8'hA5); add_byte(8'h55);
        send_range(0, stim_q.size() - 5);
        check("midrst_valid_before", 32'(o_valid), 32'h1);
        do_reset();
        o_ready = 1'b1;
        stim_q.push_back(1'b0); stim_q.push_back(1'b1);
        stim_q.push_back(1'b0); stim_q.push_back(1'b1);
        add_byte(8'h66); add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22);
        add_byte(8'hA5); add_byte(8'h77); add_byte(8'h88);
        model_run();
        send_range(0, stim_q.size() - 1);
        finish_scn("mid_reset", 1'b0);

        // Randomised frames: corrupted syncs, sync-like payload, leading junk, random gaps.
        gap_mode = 2;
        for (int s = 0; s < 20; s++) begin
            do_reset();
            repeat ($urandom_range(0, 12)) stim_q.push_back(1'($urandom_range(0, 1)));
            repeat ($urandom_range(3, 8)) begin
                if ($urandom_range(0, 4) == 0) add_byte(8'($urandom));
                else add_byte(SYNC_B);
                for (int w = 0; w < FW; w++) begin
                    if ($urandom_range(0, 5) == 0) add_byte(SYNC_B);
                    else add_byte(8'($urandom));
                end
            end
            model_run();
            send_range(0, stim_q.size() - 1);
            finish_scn("random", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_frame_deserializer.md
Name: sr_frame_deserializer

Overview:
- Consumes the serial bit stream leaving the fixed-length DFF shift chain, one bit per valid cycle.
- Hunts for a sync word and confirms lock over several consecutive frames.
- Once locked, deserialises each frame's payload into WIDTH-bit words and hands them downstream over a valid/ready interface.
- Sits directly downstream of the shift chain's serial output in the SRL test designs.

Parameters:
- WIDTH, 8, payload word width in bits.
- SYNC, 8'hA5, sync pattern (SYNC_LEN bits).
- SYNC_LEN, 8, sync pattern length in bits.
- FRAME_WORDS, 2, payload words per frame (>=1).
- LOCK_CNT, 2, consecutive sync matches required for lock (>=1).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_bit  input  1  serial data bit from shift chain output; MSB of each field first.
- i_valid  input  1  i_bit is sampled only when 1.
- o_data  output  WIDTH  payload word.
- o_valid  output  1  o_data valid; held until accepted.
- o_ready  input  1  downstream accepts when o_valid && o_ready.
- o_sof  output  1  qualifies o_data: first word of a frame.
- locked  output  1  high while in LOCKED.
- sync_lost  output  1  one-cycle pulse on loss of lock.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset: state=HUNT; window, counters and match count = 0; o_data=0, o_valid=0, o_sof=0, locked=0, sync_lost=0, overflow=0. Reset takes priority over everything, including mid-frame.
- Sampled bit: only when i_valid=1. Next window = {window[SYNC_LEN-2:0], i_bit}; all comparisons use this next value.
- Idle cycles: i_valid=0 changes nothing except handshake acceptance.
- Frame layout: SYNC_LEN sync bits, then FRAME_WORDS*WIDTH payload bits, repeating.
- HUNT: on each sampled bit, if next window == SYNC:
  - match_cnt=1;
  - go to LOCKED if LOCK_CNT==1, else VERIFY;
  - phase=PAYLOAD, bit_cnt=0.
- Phase counting (VERIFY/LOCKED):
  - PAYLOAD counts FRAME_WORDS*WIDTH sampled bits, then phase=SYNC.
  - SYNC counts SYNC_LEN sampled bits; compare at the last one.
- VERIFY:
  - Payload bits are discarded.
  - Sync match: match_cnt+1; at LOCK_CNT go to LOCKED, else stay in VERIFY.
  - Mismatch: go to HUNT, match_cnt=0, no sync_lost pulse.
- LOCKED:
  - locked=1 from the cycle after the locking edge.
  - Every WIDTH payload bits form a word, MSB first.
  - The word is presented with o_valid=1 the cycle after its last bit is sampled.
  - o_sof=1 for word index 0 of the frame.
  - Sync match: stay LOCKED.
  - Mismatch: go to HUNT, locked=0, sync_lost=1 for one cycle.
  - Hunting restarts with the current window, so a match can occur on the very next sampled bit.
- Output buffer (single entry):
  - Acceptance clears o_valid unless a new word completes in the same cycle; in that case the new word loads and o_valid stays 1.
  - A word completing while o_valid=1 and o_ready=0 is dropped; held data is unchanged and overflow is set until rst.
  - Loss of lock does not cancel a held word.
- Counter widths: clog2 of the largest count, with no wrap inside a phase.
- Phase and word counters return to 0 at each phase end.

Test Plan:
- Lock and deliver (defaults, o_ready=1): stream A5 11 22 A5 33 44 A5 55 66 A5, contiguous i_valid.
  - locked rises the cycle after the last bit of the 2nd A5.
  - Words out: 33(sof=1), 44(sof=0), 55(sof=1), 66(sof=0).
  - 11 and 22 are not emitted; overflow=0.
- Gapped input: same stream with i_valid toggling 1,0,1,0 → identical word sequence and sof flags, each word one cycle after its last valid bit.
- Backpressure: locked, hold o_ready=0 across words 33 and 44.
  - o_data stays 33, overflow=1, 44 is never output.
  - Raise o_ready → 33 accepted; next output is 55.
- Loss of lock: after lock, send 5A in place of A5.
  - sync_lost pulses once and locked falls.
  - Following A5 11 22 A5 77 88 → relock; only 77, 88 are emitted.
- False sync in payload: during VERIFY, payload byte A5 followed by a bad sync byte 00 → returns to HUNT with no lock and no words out.
- Reset mid-frame: assert rst for one cycle halfway through word 55 while o_valid=1.
  - All outputs are 0 the next cycle.
  - The remaining bits are ignored until a fresh two-sync lock.
